// File: rtl/quad_pkg.sv
// Shared types and the Gray-code phase successor for the quadrature step generator.
package quad_pkg;

    typedef enum logic [1:0] {
        Q00 = 2'b00,
        Q01 = 2'b01,
        Q11 = 2'b11,
        Q10 = 2'b10
    } quad_phase_t;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        DWELL,
        DONE
    } gen_state_t;

    localparam int BCNT_W = 5;

    // Phase is {B,A}; cw walks 00->01->11->10, ccw walks the reverse.
    function automatic quad_phase_t next_phase(quad_phase_t p, logic cw);
        quad_phase_t n;
        case (p)
            Q00:     n = cw ? Q01 : Q10;
            Q01:     n = cw ? Q11 : Q00;
            Q11:     n = cw ? Q10 : Q01;
            Q10:     n = cw ? Q00 : Q11;
            default: n = Q00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_dwell_timer.sv
// Down-counting hold timer: load a tick count, expire_o pulses in the last held cycle.
module quad_dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Count holds the remaining cycles of the current level, so 1 marks the final one.
    assign expire_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/quadrature_step_generator.sv
// Encoder emulator: turns direction+count step commands into Gray-coded A/B lines
// with a programmable dwell per phase and optional contact-bounce glitches.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// BOUNCE | changing line toggling between new and old level
// DWELL  | settled phase held for PHASE_TICKS
// DONE   | one-cycle completion strobe, may accept the next command
module quadrature_step_generator
    import quad_pkg::*;
#(
    parameter int PHASE_TICKS    = 131072,
    parameter int BOUNCE_TICKS   = 64,
    parameter int BOUNCE_TOGGLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_cw,
    input  logic [7:0] cmd_steps,
    input  logic       bounce_en,
    output logic       encoder_A,
    output logic       encoder_B,
    output logic       busy,
    output logic       done_stb,
    output logic [7:0] steps_left,
    output logic [1:0] phase
);

    localparam int TICK_MAX = (PHASE_TICKS > BOUNCE_TICKS) ? PHASE_TICKS : BOUNCE_TICKS;
    localparam int TMR_W    = $clog2(TICK_MAX + 1);
    localparam bit BOUNCE_ON = (BOUNCE_TOGGLES > 0);
    localparam logic [BCNT_W-1:0] BCNT_INIT =
        BOUNCE_ON ? BCNT_W'(2 * BOUNCE_TOGGLES - 1) : '0;

    gen_state_t        state_q;
    quad_phase_t       phase_q;
    logic [1:0]        lines_q;
    logic [1:0]        chg_q;
    logic [7:0]        steps_q;
    logic              cw_q;
    logic              bounce_q;
    logic [BCNT_W-1:0] bcnt_q;

    logic              accept;
    logic              start;
    logic              start_cw;
    logic              start_bnc;
    quad_phase_t       nxt_phase;
    logic              tmr_load;
    logic              tmr_bounce;
    logic [TMR_W-1:0]  tmr_val;
    logic              expire;

    assign accept = cmd_valid && ((state_q == IDLE) || (state_q == DONE));

    // A transition starts either on a fresh non-empty command or when a dwell
    // expires with steps still pending; both paths share the same line update.
    always_comb begin
        start      = 1'b0;
        start_cw   = cmd_cw;
        start_bnc  = bounce_en && BOUNCE_ON;
        tmr_load   = 1'b0;
        tmr_bounce = 1'b0;
        if (state_q == DWELL) begin
            start_cw  = cw_q;
            start_bnc = bounce_q;
            start     = expire && (steps_q != 8'd1);
        end else if (accept) begin
            start = (cmd_steps != 8'd0);
        end
        if (start) begin
            tmr_load   = 1'b1;
            tmr_bounce = start_bnc;
        end else if ((state_q == BOUNCE) && expire) begin
            tmr_load   = 1'b1;
            tmr_bounce = (bcnt_q != '0);
        end
    end

    assign nxt_phase = next_phase(phase_q, start_cw);
    assign tmr_val   = tmr_bounce ? TMR_W'(BOUNCE_TICKS) : TMR_W'(PHASE_TICKS);

    quad_dwell_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= Q00;
            lines_q  <= 2'b00;
            chg_q    <= 2'b00;
            steps_q  <= 8'd0;
            cw_q     <= 1'b0;
            bounce_q <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        steps_q  <= cmd_steps;
                        cw_q     <= cmd_cw;
                        bounce_q <= bounce_en && BOUNCE_ON;
                        state_q  <= DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BOUNCE: begin
                    if (expire) begin
                        if (bcnt_q != '0) begin
                            lines_q <= lines_q ^ chg_q;
                            bcnt_q  <= bcnt_q - 1'b1;
                        end else begin
                            lines_q <= phase_q;
                            state_q <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (expire) begin
                        steps_q <= steps_q - 8'd1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Later assignment overrides the DONE chosen above when work remains.
            if (start) begin
                phase_q <= nxt_phase;
                lines_q <= nxt_phase;
                chg_q   <= nxt_phase ^ phase_q;
                bcnt_q  <= BCNT_INIT;
                state_q <= start_bnc ? BOUNCE : DWELL;
            end
        end
    end

    assign cmd_ready  = (state_q == IDLE) || (state_q == DONE);
    assign busy       = (state_q == BOUNCE) || (state_q == DWELL);
    assign done_stb   = (state_q == DONE);
    assign encoder_A  = lines_q[0];
    assign encoder_B  = lines_q[1];
    assign steps_left = steps_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Scoreboard bench for quadrature_step_generator: expected line/done events are queued
// at command acceptance and popped by a monitor whenever the DUT shows an event.
module tb_quadrature_step_generator;

    localparam int PT  = 4;
    localparam int BT  = 2;
    localparam int TOG = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_cw = 1'b0;
    logic [7:0] cmd_steps = 8'd0;
    logic       bounce_en = 1'b0;
    logic       cmd_ready;
    logic       encoder_A;
    logic       encoder_B;
    logic       busy;
    logic       done_stb;
    logic [7:0] steps_left;
    logic [1:0] phase;

    quadrature_step_generator #(
        .PHASE_TICKS    (PT),
        .BOUNCE_TICKS   (BT),
        .BOUNCE_TOGGLES (TOG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_cw     (cmd_cw),
        .cmd_steps  (cmd_steps),
        .bounce_en  (bounce_en),
        .encoder_A  (encoder_A),
        .encoder_B  (encoder_B),
        .busy       (busy),
        .done_stb   (done_stb),
        .steps_left (steps_left),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int cyc;
        int kind;   // 0 = line change, 1 = done_stb
        int val;
    } ev_t;

    ev_t        sb_q[$];
    logic [1:0] m_phase    = 2'b00;
    bit         mon_en     = 1'b0;
    logic [1:0] prev_lines = 2'b00;
    logic [1:0] mon_cur;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [1:0] nxt(input logic [1:0] p, input logic cw);
        logic [1:0] r;
        case (p)
            2'b00:   r = cw ? 2'b01 : 2'b10;
            2'b01:   r = cw ? 2'b11 : 2'b00;
            2'b11:   r = cw ? 2'b10 : 2'b01;
            default: r = cw ? 2'b00 : 2'b11;
        endcase
        return r;
    endfunction

    task automatic push_ev(input int c, input int k, input int v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic push_cmd(input logic cw, input int steps, input logic bnc, input int n,
                            input bit with_done, output int done_c);
        int p;
        int t0;
        logic [1:0] np;
        p = PT + (bnc ? 2 * TOG * BT : 0);
        for (int k = 0; k < steps; k++) begin
            t0 = n + k * p;
            np = nxt(m_phase, cw);
            if (bnc) begin
                for (int j = 0; j <= 2 * TOG; j++)
                    push_ev(t0 + j * BT, 0, ((j % 2) == 0) ? int'(np) : int'(m_phase));
            end else begin
                push_ev(t0, 0, int'(np));
            end
            m_phase = np;
        end
        done_c = n + steps * p;
        if (with_done) push_ev(done_c, 1, 0);
    endtask

    task automatic sb_pop(input int kind, input int val);
        ev_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.cyc  = -1;
            e.kind = -1;
            e.val  = -1;
        end
        chk((kind == 0) ? "line_event_cycle" : "done_event_cycle", cyc, e.cyc);
        chk((kind == 0) ? "line_event_value" : "done_event_kind", kind * 4 + val, e.kind * 4 + e.val);
    endtask

    always @(negedge clk) begin
        mon_cur = {encoder_B, encoder_A};
        if (mon_en) begin
            if (mon_cur != prev_lines) begin
                chk("one_line_change", $countones(mon_cur ^ prev_lines), 1);
                sb_pop(0, int'(mon_cur));
            end
            if (done_stb) sb_pop(1, 0);
        end
        prev_lines = mon_cur;
    end

    task automatic send(input logic cw, input int steps, input logic bnc, input bit hold,
                        input int exp_n, input int mdl_steps, input bit mdl_done,
                        output int n, output int dc);
        int w;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_cw    = cw;
        cmd_steps = 8'(steps);
        bounce_en = bnc;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_seen", int'(cmd_ready), 1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            n  = -1;
            dc = -1;
            return;
        end
        n = cyc + 1;
        if (exp_n >= 0) chk("accept_cycle", n, exp_n);
        push_cmd(cw, mdl_steps, bnc, n, mdl_done, dc);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int dc;
        int dc1;
        logic [1:0] exp_steps[3];

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_A", int'(encoder_A), 0);
        chk("rst_B", int'(encoder_B), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_stb), 0);
        chk("rst_steps_left", int'(steps_left), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        mon_en = 1'b1;

        // cw 4 steps: 01,11,10,00 each held 4 clocks
        send(1'b1, 4, 1'b0, 1'b0, -1, 4, 1'b1, n, dc);
        chk("t1_busy", int'(busy), 1);
        chk("t1_ready_busy", int'(cmd_ready), 0);
        drain(100);
        chk("t1_phase_end", int'(phase), 2'b00);

        // ccw 3 steps: 10,11,01 with steps_left 3,2,1,0
        exp_steps[0] = 2'd2;
        exp_steps[1] = 2'd1;
        exp_steps[2] = 2'd0;
        send(1'b0, 3, 1'b0, 1'b0, -1, 3, 1'b1, n, dc);
        chk("t2_steps_left_0", int'(steps_left), 3);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge clk);
            #1;
            chk("t2_steps_left", int'(steps_left), int'(exp_steps[i]));
        end
        drain(100);
        chk("t2_phase_end", int'(phase), 2'b01);

        send(1'b0, 1, 1'b0, 1'b0, -1, 1, 1'b1, n, dc);
        drain(100);
        chk("t3_phase_home", int'(phase), 2'b00);

        // cw 1 step with bounce: A 1,0 then settled 1; B stays 0
        send(1'b1, 1, 1'b1, 1'b0, -1, 1, 1'b1, n, dc);
        chk("t4_A_first", int'(encoder_A), 1);
        chk("t4_B_first", int'(encoder_B), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_A_glitch", int'(encoder_A), 0);
        chk("t4_B_glitch", int'(encoder_B), 0);
        chk("t4_phase_mid", int'(phase), 2'b01);
        drain(100);
        chk("t4_phase_end", int'(phase), 2'b01);

        // zero-step command completes immediately with no motion
        send(1'b1, 0, 1'b0, 1'b0, -1, 0, 1'b1, n, dc);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done_stb), 1);
        chk("t5_phase", int'(phase), 2'b01);
        chk("t5_ready", int'(cmd_ready), 1);
        drain(20);

        // cmd_valid held: second command taken in the done cycle of the first
        send(1'b1, 2, 1'b0, 1'b1, -1, 2, 1'b1, n, dc1);
        send(1'b0, 2, 1'b1, 1'b0, dc1 + 1, 2, 1'b1, n, dc);
        drain(200);
        chk("t6_phase_end", int'(phase), 2'b01);

        // reset pulsed in the second dwell of a 10-step command
        send(1'b1, 10, 1'b0, 1'b0, -1, 2, 1'b0, n, dc);
        repeat (5) @(negedge clk);
        push_ev(cyc + 1, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_phase = 2'b00;
        chk("t7_A", int'(encoder_A), 0);
        chk("t7_B", int'(encoder_B), 0);
        chk("t7_phase", int'(phase), 0);
        chk("t7_done", int'(done_stb), 0);
        @(posedge clk);
        #1;
        chk("t7_ready", int'(cmd_ready), 1);
        chk("t7_busy", int'(busy), 0);
        chk("t7_steps_left", int'(steps_left), 0);
        repeat (60) @(negedge clk);
        chk("t7_no_late_events", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
